// File: rtl/spu_fwd_pkg.sv
// Shared types for the SPU operand-forwarding controller: mux select encoding,
// scoreboard entry layout and the latency clamp used at insertion.
package spu_fwd_pkg;

    localparam int unsigned ADDR_W  = 7;
    localparam int unsigned LAT_W   = 3;
    localparam int unsigned MAX_LAT = 7;

    typedef enum logic [1:0] {
        FWD_RF   = 2'b00,
        FWD_NEAR = 2'b01,
        FWD_WB   = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rt;
        logic [LAT_W-1:0]  lat;
    } sb_entry_t;

    // Zero latency behaves as one cycle; anything past the deepest slot is capped.
    function automatic logic [LAT_W-1:0] clamp_lat(input logic [LAT_W-1:0] lat,
                                                   input int unsigned max_lat);
        if (lat == '0)
            return LAT_W'(1);
        else if (32'(lat) > max_lat)
            return LAT_W'(max_lat);
        else
            return lat;
    endfunction

endpackage

// File: rtl/spu_fwd_lookup.sv
// Priority search of the scoreboard for one source register; the youngest
// (lowest-slot) match alone decides the select and readiness.
// Near-bus forwarding is compiled in only when SPU_FWD_NEAR_EN is defined.
module spu_fwd_lookup
    import spu_fwd_pkg::*;
#(
    parameter int unsigned NSLOT = MAX_LAT + 1
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  sb_entry_t         i_sb [1:NSLOT],
    output fwd_sel_t          o_sel_c,
    output logic              o_ready_c
);

    // Walk oldest to youngest so the youngest matching slot is written last.
    always_comb begin
        o_sel_c   = FWD_RF;
        o_ready_c = 1'b1;
        for (int unsigned k = NSLOT; k >= 1; k--) begin
            if (i_sb[k].valid && (i_sb[k].rt == i_addr)) begin
`ifdef SPU_FWD_NEAR_EN
                if (k < 32'(i_sb[k].lat)) begin
                    o_sel_c   = FWD_RF;
                    o_ready_c = 1'b0;
                end else if (k == 32'(i_sb[k].lat)) begin
                    o_sel_c   = FWD_NEAR;
                    o_ready_c = 1'b1;
                end else if (k == 32'(i_sb[k].lat) + 32'd1) begin
`else
                if (k <= 32'(i_sb[k].lat)) begin
                    o_sel_c   = FWD_RF;
                    o_ready_c = 1'b0;
                end else if (k == 32'(i_sb[k].lat) + 32'd1) begin
`endif
                    o_sel_c   = FWD_WB;
                    o_ready_c = 1'b1;
                end else begin
                    o_sel_c   = FWD_RF;
                    o_ready_c = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/spu_fwd_ctrl.sv
// Operand-forwarding controller: shift-register scoreboard of in-flight writes,
// per-source forwarding selects and issue stall. Optional macro: SPU_FWD_NEAR_EN.
module spu_fwd_ctrl
    import spu_fwd_pkg::*;
#(
    parameter int unsigned addrWidth = ADDR_W,
    parameter int unsigned maxLat    = MAX_LAT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issue_valid,
    input  logic                 issue_we,
    input  logic [addrWidth-1:0] issue_rt,
    input  logic [2:0]           issue_lat,
    input  logic [addrWidth-1:0] ra_addr,
    input  logic [addrWidth-1:0] rb_addr,
    output fwd_sel_t             ra_sel,
    output fwd_sel_t             rb_sel,
    output logic                 stall
);

    localparam int unsigned NSLOT = maxLat + 1;

    sb_entry_t r_sb [1:NSLOT];
    sb_entry_t w_new;
    logic      w_ra_ready;
    logic      w_rb_ready;
    logic      w_ins;

    spu_fwd_lookup #(.NSLOT(NSLOT)) u_lookup_ra (
        .i_addr    (ADDR_W'(ra_addr)),
        .i_sb      (r_sb),
        .o_sel_c   (ra_sel),
        .o_ready_c (w_ra_ready)
    );

    spu_fwd_lookup #(.NSLOT(NSLOT)) u_lookup_rb (
        .i_addr    (ADDR_W'(rb_addr)),
        .i_sb      (r_sb),
        .o_sel_c   (rb_sel),
        .o_ready_c (w_rb_ready)
    );

    assign stall = issue_valid & ~(w_ra_ready & w_rb_ready);
    assign w_ins = issue_valid & issue_we & ~stall;

    // Entry loaded into slot 1; a bubble when nothing is accepted.
    always_comb begin
        w_new = '0;
        if (w_ins) begin
            w_new.valid = 1'b1;
            w_new.rt    = ADDR_W'(issue_rt);
            w_new.lat   = clamp_lat(LAT_W'(issue_lat), maxLat);
        end
    end

    // Unconditional shift; an entry dies on the move that would land it in slot lat+2.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 1; k <= NSLOT; k++)
                r_sb[k] <= '0;
        end else begin
            r_sb[1] <= w_new;
            for (int unsigned k = 2; k <= NSLOT; k++)
                r_sb[k] <= '{valid: r_sb[k-1].valid && (32'(r_sb[k-1].lat) + 32'd1 >= k),
                             rt:    r_sb[k-1].rt,
                             lat:   r_sb[k-1].lat};
        end
    end

endmodule

// File: tb/tb_spu_fwd_ctrl.sv
// Directed bench for spu_fwd_ctrl; expectations follow SPU_FWD_NEAR_EN when defined.
module tb_spu_fwd_ctrl;

`ifdef SPU_FWD_NEAR_EN
    localparam bit NEAR = 1'b1;
`else
    localparam bit NEAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       issue_valid;
    logic       issue_we;
    logic [6:0] issue_rt;
    logic [2:0] issue_lat;
    logic [6:0] ra_addr;
    logic [6:0] rb_addr;
    logic [1:0] ra_sel, rb_sel, ra_sel5, rb_sel5;
    logic       stall, stall5;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    spu_fwd_ctrl dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_we(issue_we),
        .issue_rt(issue_rt), .issue_lat(issue_lat), .ra_addr(ra_addr), .rb_addr(rb_addr),
        .ra_sel(ra_sel), .rb_sel(rb_sel), .stall(stall)
    );

    spu_fwd_ctrl #(.maxLat(5)) dut5 (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_we(issue_we),
        .issue_rt(issue_rt), .issue_lat(issue_lat), .ra_addr(ra_addr), .rb_addr(rb_addr),
        .ra_sel(ra_sel5), .rb_sel(rb_sel5), .stall(stall5)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic we, input logic [6:0] rt,
                          input logic [2:0] lat, input logic [6:0] ra, input logic [6:0] rb);
        issue_valid = v;
        issue_we    = we;
        issue_rt    = rt;
        issue_lat   = lat;
        ra_addr     = ra;
        rb_addr     = rb;
    endtask

    task automatic idle(input int n);
        set_in(1'b0, 1'b0, 7'd0, 3'd0, 7'd127, 7'd127);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        set_in(1'b0, 1'b0, 7'd0, 3'd0, 7'd127, 7'd127);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idle(1);

        // Reset: pre-reset producer and reset-cycle issue must both vanish.
        set_in(1'b1, 1'b1, 7'd20, 3'd3, 7'd127, 7'd127);
        @(negedge clk);
        reset = 1'b1;
        set_in(1'b1, 1'b1, 7'd5, 3'($urandom_range(0, 7)),
               7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)));
        @(negedge clk);
        #1;
        check("rst_stall", stall, 0);
        check("rst_ra_sel", ra_sel, 0);
        check("rst_rb_sel", rb_sel, 0);
        @(negedge clk);
        reset = 1'b0;
        set_in(1'b1, 1'b0, 7'd0, 3'd0, 7'd20, 7'd5);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("post_rst_stall", stall, 0);
            check("post_rst_ra", ra_sel, 0);
            check("post_rst_rb", rb_sel, 0);
            @(negedge clk);
        end
        idle(9);

        // rt=5 lat=2: pending, near, writeback, register file.
        set_in(1'b1, 1'b1, 7'd5, 3'd2, 7'd127, 7'd127);
        @(negedge clk);
        set_in(1'b1, 1'b0, 7'd0, 3'd0, 7'd5, 7'd127);
        #1; check("l2_c1_stall", stall, 1); check("l2_c1_ra", ra_sel, 0);
        @(negedge clk);
        #1; check("l2_c2_stall", stall, NEAR ? 0 : 1); check("l2_c2_ra", ra_sel, NEAR ? 1 : 0);
        @(negedge clk);
        #1; check("l2_c3_stall", stall, 0); check("l2_c3_ra", ra_sel, 2);
        @(negedge clk);
        #1; check("l2_c4_stall", stall, 0); check("l2_c4_ra", ra_sel, 0);
        idle(9);

        // Two producers to rt=9: younger lat=1 wins, then older lat=6 takes over.
        set_in(1'b1, 1'b1, 7'd9, 3'd6, 7'd127, 7'd127);
        @(negedge clk);
        set_in(1'b1, 1'b1, 7'd9, 3'd1, 7'd127, 7'd127);
        @(negedge clk);
        set_in(1'b1, 1'b0, 7'd0, 3'd0, 7'd127, 7'd9);
        #1; check("dup_c2_rb", rb_sel, NEAR ? 1 : 0); check("dup_c2_stall", stall, NEAR ? 0 : 1);
        @(negedge clk);
        #1; check("dup_c3_rb", rb_sel, 2); check("dup_c3_stall", stall, 0);
        @(negedge clk);
        #1; check("dup_c4_stall", stall, 1);
        @(negedge clk);
        #1; check("dup_c5_stall", stall, 1);
        @(negedge clk);
        #1; check("dup_c6_rb", rb_sel, NEAR ? 1 : 0); check("dup_c6_stall", stall, NEAR ? 0 : 1);
        @(negedge clk);
        #1; check("dup_c7_rb", rb_sel, 2);
        @(negedge clk);
        #1; check("dup_c8_rb", rb_sel, 0);
        idle(9);

        // Younger pending hides an older forwardable result.
        set_in(1'b1, 1'b1, 7'd11, 3'd1, 7'd127, 7'd127);
        @(negedge clk);
        set_in(1'b1, 1'b1, 7'd11, 3'd3, 7'd127, 7'd127);
        @(negedge clk);
        set_in(1'b1, 1'b0, 7'd0, 3'd0, 7'd11, 7'd127);
        #1; check("hide_stall", stall, 1); check("hide_ra", ra_sel, 0);
        idle(9);

        // rt=3 lat=7 read on both sources; valid low must not stall.
        set_in(1'b1, 1'b1, 7'd3, 3'd7, 7'd127, 7'd127);
        @(negedge clk);
        set_in(1'b0, 1'b0, 7'd0, 3'd0, 7'd3, 7'd3);
        #1; check("l7_novalid_stall", stall, 0);
        @(negedge clk);
        issue_valid = 1'b1;
        for (int c = 2; c <= 6; c++) begin
            #1; check("l7_pend_stall", stall, 1);
            @(negedge clk);
        end
        #1; check("l7_c7_stall", stall, NEAR ? 0 : 1);
        check("l7_c7_ra", ra_sel, NEAR ? 1 : 0); check("l7_c7_rb", rb_sel, NEAR ? 1 : 0);
        @(negedge clk);
        #1; check("l7_c8_stall", stall, 0); check("l7_c8_ra", ra_sel, 2); check("l7_c8_rb", rb_sel, 2);
        @(negedge clk);
        #1; check("l7_c9_ra", ra_sel, 0); check("l7_c9_rb", rb_sel, 0);
        idle(9);

        // Self-read: rt=12 reading ra=12 sees the older producer only.
        set_in(1'b1, 1'b1, 7'd12, 3'd1, 7'd127, 7'd127);
        @(negedge clk);
        set_in(1'b1, 1'b1, 7'd12, 3'd1, 7'd12, 7'd127);
        #1; check("self_c1_stall", stall, NEAR ? 0 : 1); check("self_c1_ra", ra_sel, NEAR ? 1 : 0);
        @(negedge clk);
        set_in(1'b1, 1'b0, 7'd0, 3'd0, 7'd12, 7'd127);
        #1; check("self_c2_stall", stall, 0); check("self_c2_ra", ra_sel, NEAR ? 1 : 2);
        idle(9);

        // Latency 0 behaves as 1 on both instances.
        set_in(1'b1, 1'b1, 7'd4, 3'd0, 7'd127, 7'd127);
        @(negedge clk);
        set_in(1'b1, 1'b0, 7'd0, 3'd0, 7'd4, 7'd127);
        #1; check("lat0_c1_ra", ra_sel, NEAR ? 1 : 0); check("lat0_c1_ra5", ra_sel5, NEAR ? 1 : 0);
        check("lat0_c1_stall", stall, NEAR ? 0 : 1);
        @(negedge clk);
        #1; check("lat0_c2_ra", ra_sel, 2); check("lat0_c2_ra5", ra_sel5, 2);
        @(negedge clk);
        #1; check("lat0_c3_ra", ra_sel, 0);
        idle(9);

        // Latency 7 on the maxLat=5 instance is capped to 5.
        set_in(1'b1, 1'b1, 7'd6, 3'd7, 7'd127, 7'd127);
        @(negedge clk);
        set_in(1'b1, 1'b0, 7'd0, 3'd0, 7'd127, 7'd6);
        for (int c = 1; c <= 4; c++) begin
            #1; check("cap_pend_stall5", stall5, 1);
            @(negedge clk);
        end
        #1; check("cap_c5_stall5", stall5, NEAR ? 0 : 1); check("cap_c5_rb5", rb_sel5, NEAR ? 1 : 0);
        check("cap_c5_stall7", stall, 1);
        @(negedge clk);
        #1; check("cap_c6_rb5", rb_sel5, 2); check("cap_c6_stall5", stall5, 0);
        @(negedge clk);
        #1; check("cap_c7_rb5", rb_sel5, 0);
        idle(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/spu_fwd_ctrl.md
# spu_fwd_ctrl

Operand-forwarding controller for the SPU operand stage, directly upstream of the 128-bit 3:1 operand muxes. It tracks every in-flight register write from issue to writeback in a shift-register scoreboard. For each of two source operands it produces the 2-bit mux select: register file, near-forward bus, or writeback-forward bus. When a source depends on a result not yet produced, it asserts a stall that holds issue.

## Interface
- `addrWidth`, 7, register address width (128 registers)
- `maxLat`, 7, longest execution latency in cycles; scoreboard holds `maxLat+1` slots
- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high; clears scoreboard
- `issue_valid`  in  1  an instruction is presented for issue this cycle
- `issue_we`  in  1  presented instruction writes a destination register
- `issue_rt`  in  addrWidth  destination register address
- `issue_lat`  in  3  execution latency of presented instruction
- `ra_addr`, `rb_addr`  in  addrWidth  source register addresses of presented instruction
- `ra_sel`, `rb_sel`  out  2  operand mux selects: 00 = register file, 01 = near-forward bus, 10 = writeback-forward bus; 11 never driven
- `stall`  out  1  presented instruction must not issue this cycle

## Operation
- Scoreboard: slots 1..`maxLat+1`; each slot holds {valid, rt, lat}.
- All slots shift by one every cycle, unconditionally, because the downstream pipeline never stalls. Slot `maxLat+1` drops off.
- Insert into slot 1 when `issue_valid & issue_we & ~stall`. Otherwise slot 1 loads an invalid bubble.
- Latency clamp before storage: `issue_lat` 0 is stored as 1; values above `maxLat` are stored as `maxLat`.
- An entry in slot k with latency L has one of four states:
  - k < L: pending (result not yet produced)
  - k == L: on the near-forward bus
  - k == L+1: on the writeback bus
  - k > L+1: invalidated (the result is in the register file)
- An entry is invalidated at the shift that would move it to slot L+2.
- Per-source match: compare the source address against every valid slot's rt. The youngest match (lowest slot index) alone decides the result:
  - no match: sel 00
  - youngest match near: sel 01
  - youngest match writeback: sel 10
  - youngest match pending: sel 00 and the source is not ready
- `stall = issue_valid & (ra not ready | rb not ready)`.
- Sources are checked against the scoreboard before the presented instruction's own insertion. An instruction reading its own rt sees the older producer, never itself.
- `ra_addr == rb_addr` is legal; both selects are evaluated independently and come out identical.
- Selects and stall are combinational from registered scoreboard state plus current inputs.
- When `issue_valid` = 0, the selects are still computed (don't-care for the consumer) and `stall` = 0.

## Timing
- Reset: all slot valid bits = 0. Therefore `ra_sel` = `rb_sel` = 00 and `stall` = 0 the cycle after `reset` is sampled high.
- A `reset` asserted mid-operation discards all in-flight entries. An insertion requested in the same cycle as `reset` is dropped.
- A producer accepted at cycle T with latency L:
  - cycles T+1 .. T+L-1: pending (consumer stalls)
  - cycle T+L: near-forward (sel 01)
  - cycle T+L+1: writeback (sel 10)
  - cycle T+L+2 onward: register file (sel 00)
- Stall has zero cycles of latency: the held instruction is re-presented by upstream and re-evaluated each cycle.
- Two producers to the same rt in flight: the younger always wins, even while the younger is pending and the older is forwardable (stall).

## Configuration
- `SPU_FWD_NEAR_EN` defined: near-forward path enabled as described.
- `SPU_FWD_NEAR_EN` undefined:
  - sel 01 is never produced
  - an entry at k == L counts as pending (stall); the first forward comes from the writeback bus at k == L+1
  - the near-bus comparison logic is removed

## Structure
- Shared package `spu_fwd_pkg`: `fwd_sel_t` enum (`FWD_RF`=2'b00, `FWD_NEAR`=2'b01, `FWD_WB`=2'b10) and the `sb_entry_t` struct {valid, rt, lat}.
- The mux select port in the operand stage uses `fwd_sel_t` values directly.
- One sub-module: `spu_fwd_lookup`, a combinational priority search over the scoreboard for one source address, returning {sel, ready}. It is instantiated twice, once for ra and once for rb.

## Test plan
- Reset with random inputs, `reset`=1 for 2 cycles → `stall`=0, both sels 00, then no forwarding from any pre-reset issue.
- Producer rt=5, lat=2 accepted at cycle 0; consumer `ra_addr`=5 presented from cycle 1 → cycle 1 `stall`=1; cycle 2 `ra_sel`=01, `stall`=0.
- Same producer, consumer first presented at cycle 3 → `ra_sel`=10; at cycle 4 → `ra_sel`=00.
- Producer A rt=9 lat=6 at cycle 0, producer B rt=9 lat=1 at cycle 1; consumer `rb_addr`=9 at cycle 2 → `rb_sel`=01 (B is youngest). At cycle 6, A is near but B is gone → `rb_sel`=01, sourced from A.
- Producer rt=3 lat=7 at cycle 0; consumer reads `ra_addr`=3, `rb_addr`=3 → stall cycles 1–6, both sels 01 at cycle 7. With `SPU_FWD_NEAR_EN` undefined: stall cycles 1–7, both sels 10 at cycle 8.
- Producer rt=4 with `issue_lat`=0, and another with `issue_lat`=7 while `maxLat`=5 → treated as lat 1 and lat 5 (near at T+1 and T+5 respectively).
